// File: rtl/wspr_sched.sv
// WSPR transmit scheduler: host-loaded 256x2 symbol memory, slot-synchronised
// start, fixed-length symbol timing, carrier enable and FSK tone index output.
module wspr_sched #(
  parameter int SYM_TICKS = 34133333,
  parameter int SYM_COUNT = 162
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        slot_sync,
  output logic        tx_en,
  output logic [1:0]  tone,
  output logic [7:0]  sym_idx,
  output logic [1:0]  state,
  output logic        done
);

  localparam int TICK_W = (SYM_TICKS > 1) ? $clog2(SYM_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SYM_TICKS - 1);
  localparam logic [8:0]        SYM_LAST  = 9'(SYM_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TX    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              arm_q, arm_d;
  logic              rep_q, rep_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [8:0]        sym_cnt_q, sym_cnt_d;
  logic              tx_en_q, tx_en_d;
  logic [1:0]        tone_q, tone_d;
  logic [7:0]        sym_idx_q, sym_idx_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic              sync_meta_q, sync_q, sync_prev_q;
  logic              sync_pulse_q, sync_pulse_d;

  logic [1:0] mem [256];

  logic ctrl_wr, sym_wr, abort_wr, tick_end, last_sym, fetch;
  logic unused_cfg;

  assign unused_cfg = ^cfg_data[7:3];

  // NOTE: the symbol memory has no reset; the host reloads it, and leaving it
  // out of the reset tree lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (sym_wr) mem[cfg_data[15:8]] <= cfg_data[1:0];
  end

  always_comb begin
    ctrl_wr      = cfg_we && !cfg_addr;
    sym_wr       = cfg_we && cfg_addr;
    abort_wr     = ctrl_wr && cfg_data[2];
    tick_end     = (tick_q == TICK_LAST);
    last_sym     = (state_q == S_TX) && tick_end && (sym_cnt_q == SYM_LAST);
    fetch        = (state_q == S_TX) && (tick_q == '0);
    sync_pulse_d = sync_q && !sync_prev_q;

    // NOTE: every combinational output gets a default first so no path
    // through the case below can infer a latch.
    state_d   = state_q;
    arm_d     = arm_q;
    rep_d     = rep_q;
    tick_d    = '0;
    sym_cnt_d = '0;

    if (ctrl_wr) begin
      arm_d = cfg_data[0] && !cfg_data[2];
      rep_d = cfg_data[1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_wr && cfg_data[0] && !cfg_data[2]) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (ctrl_wr && !cfg_data[0]) state_d = S_IDLE;
        else if (sync_pulse_q)       state_d = S_TX;
      end
      S_TX: begin
        tick_d    = tick_end ? '0 : tick_q + TICK_W'(1);
        sym_cnt_d = tick_end ? sym_cnt_q + 9'd1 : sym_cnt_q;
        if (last_sym) begin
          sym_cnt_d = '0;
          if (rep_q && arm_q) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
            arm_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides slot start and end-of-message handling.
    if (abort_wr) begin
      state_d   = S_IDLE;
      arm_d     = 1'b0;
      tick_d    = '0;
      sym_cnt_d = '0;
    end

    // Tone is latched only at the start of a symbol, so rewriting the index
    // currently on air never disturbs it; a same-cycle write reads old data.
    tx_en_d   = (state_q == S_TX) && !abort_wr;
    tone_d    = tone_q;
    sym_idx_d = sym_idx_q;
    if (!tx_en_d) begin
      tone_d    = '0;
      sym_idx_d = '0;
    end else if (fetch) begin
      tone_d    = mem[sym_cnt_q[7:0]];
      sym_idx_d = sym_cnt_q[7:0];
    end

    fin_d  = last_sym && !abort_wr && !(rep_q && arm_q);
    done_d = fin_q && !abort_wr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      arm_q        <= 1'b0;
      rep_q        <= 1'b0;
      tick_q       <= '0;
      sym_cnt_q    <= '0;
      tx_en_q      <= 1'b0;
      tone_q       <= '0;
      sym_idx_q    <= '0;
      fin_q        <= 1'b0;
      done_q       <= 1'b0;
      sync_meta_q  <= 1'b0;
      sync_q       <= 1'b0;
      sync_prev_q  <= 1'b0;
      sync_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      rep_q        <= rep_d;
      tick_q       <= tick_d;
      sym_cnt_q    <= sym_cnt_d;
      tx_en_q      <= tx_en_d;
      tone_q       <= tone_d;
      sym_idx_q    <= sym_idx_d;
      fin_q        <= fin_d;
      done_q       <= done_d;
      sync_meta_q  <= slot_sync;
      sync_q       <= sync_meta_q;
      sync_prev_q  <= sync_q;
      sync_pulse_q <= sync_pulse_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tone    = tone_q;
  assign sym_idx = sym_idx_q;
  assign state   = state_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wspr_sched.sv
// Directed bench for wspr_sched with SYM_TICKS=4, SYM_COUNT=3: basic burst,
// repeat, abort, sync during TX, async reset, disarm and memory write timing.
module tb_wspr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic        cfg_addr;
  logic [15:0] cfg_data;
  logic        slot_sync;
  logic        tx_en;
  logic [1:0]  tone;
  logic [7:0]  sym_idx;
  logic [1:0]  state;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  wspr_sched #(.SYM_TICKS(4), .SYM_COUNT(3)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .slot_sync(slot_sync), .tx_en(tx_en), .tone(tone),
    .sym_idx(sym_idx), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic load_syms(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
    cfg_write(1'b1, {8'd0, 6'd0, s0});
    cfg_write(1'b1, {8'd1, 6'd0, s1});
    cfg_write(1'b1, {8'd2, 6'd0, s2});
  endtask

  task automatic sync_edge();
    slot_sync = 1'b1;
    tick();
    tick();
    slot_sync = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (tx_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "/tx_start"}, 32'(tx_en), 32'd1);
  endtask

  task automatic no_tx(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (tx_en !== 1'b0) seen = 1'b1;
    end
    check({tag, "/no_tx"}, 32'(seen), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/tx_en"},   32'(tx_en),   32'd0);
    check({tag, "/tone"},    32'(tone),    32'd0);
    check({tag, "/sym_idx"}, 32'(sym_idx), 32'd0);
    check({tag, "/state"},   32'(state),   32'd0);
    check({tag, "/done"},    32'(done),    32'd0);
  endtask

  // act: 0 none, 1 sync edge at TX cycle 6, 2 symbol writes during symbol 0,
  // 3 abort at TX cycle 5, 4 async reset at TX cycle 7.
  task automatic run_burst(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input int act,
                           input logic [1:0] exp_state, input logic exp_done);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] e;
      e = (i < 4) ? e0 : (i < 8) ? e1 : e2;
      check($sformatf("%s/tx_en[%0d]", tag, i),   32'(tx_en),   32'd1);
      check($sformatf("%s/tone[%0d]", tag, i),    32'(tone),    32'(e));
      check($sformatf("%s/sym_idx[%0d]", tag, i), 32'(sym_idx), 32'(i / 4));
      if (act == 3 && i == 4) begin
        cfg_write(1'b0, 16'h0004);
        check({tag, "/abort_tx_en"}, 32'(tx_en), 32'd0);
        check({tag, "/abort_state"}, 32'(state), 32'd0);
        check({tag, "/abort_done"},  32'(done),  32'd0);
        tick();
        check({tag, "/abort_done2"}, 32'(done),  32'd0);
        return;
      end
      if (act == 4 && i == 6) begin
        #3 rst = 1'b1;
        #1 check_reset_outputs({tag, "/async_rst"});
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (act == 1 && i == 5) slot_sync = 1'b1;
      if (act == 2) begin
        if (i == 1) begin cfg_we = 1'b1; cfg_addr = 1'b1; cfg_data = {8'd0, 8'd0}; end
        if (i == 2) cfg_data = {8'd2, 8'd0};
        if (i == 3) cfg_data = {8'd1, 8'd0};
        if (i == 4) cfg_we = 1'b0;
      end
      tick();
    end
    slot_sync = 1'b0;
    check({tag, "/end_tx_en"}, 32'(tx_en), 32'd0);
    check({tag, "/end_done"},  32'(done),  32'(exp_done));
    check({tag, "/end_state"}, 32'(state), 32'(exp_state));
    tick();
    check({tag, "/done_gone"}, 32'(done),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 1'b0;
    cfg_data  = '0;
    slot_sync = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset_hold");
    rst = 1'b0;
    tick();
    check_reset_outputs("reset_release");

    // Basic transmission
    load_syms(2'd1, 2'd3, 2'd2);
    cfg_write(1'b0, 16'h0001);
    check("basic/armed", 32'(state), 32'd1);
    sync_edge();
    wait_tx("basic");
    run_burst("basic", 2'd1, 2'd3, 2'd2, 0, 2'd0, 1'b1);

    // Repeat: two bursts from two slot edges 20 cycles apart
    cfg_write(1'b0, 16'h0003);
    check("rep/armed", 32'(state), 32'd1);
    sync_edge();
    wait_tx("rep1");
    run_burst("rep1", 2'd1, 2'd3, 2'd2, 0, 2'd1, 1'b0);
    tick();
    tick();
    check("rep/between_state", 32'(state), 32'd1);
    sync_edge();
    wait_tx("rep2");
    run_burst("rep2", 2'd1, 2'd3, 2'd2, 0, 2'd1, 1'b0);

    // Disarm while ARMED, then a slot edge must not transmit
    cfg_write(1'b0, 16'h0000);
    check("disarm/state", 32'(state), 32'd0);
    sync_edge();
    no_tx("disarm", 20);
    check("disarm/state_after", 32'(state), 32'd0);

    // Abort mid-transmission clears arm
    cfg_write(1'b0, 16'h0001);
    sync_edge();
    wait_tx("abort");
    run_burst("abort", 2'd1, 2'd3, 2'd2, 3, 2'd0, 1'b0);
    sync_edge();
    no_tx("abort_after", 20);

    // Second slot edge during TX is ignored
    cfg_write(1'b0, 16'h0001);
    sync_edge();
    wait_tx("sync_in_tx");
    run_burst("sync_in_tx", 2'd1, 2'd3, 2'd2, 1, 2'd0, 1'b1);
    no_tx("sync_in_tx_after", 15);

    // Async reset mid-transmission
    cfg_write(1'b0, 16'h0001);
    sync_edge();
    wait_tx("rst");
    run_burst("rst", 2'd1, 2'd3, 2'd2, 4, 2'd0, 1'b0);
    check_reset_outputs("rst_after");
    sync_edge();
    no_tx("rst_after", 20);

    // Memory writes during TX: held and same-cycle-fetched symbols keep old data
    load_syms(2'd1, 2'd3, 2'd2);
    cfg_write(1'b0, 16'h0001);
    sync_edge();
    wait_tx("memwr");
    run_burst("memwr", 2'd1, 2'd3, 2'd0, 2, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
